ddi_phase_scheduler: RTL and testbench

Timing and arbitration controller for one diverging-diamond signal FSM. It observes the FSM's `current_state` and generates the `timing_done`, `phase`, `sync` and `maintenance` inputs that sequence the FSM. It times each state's residency and alternates the two normal phases. It also arbitrates eastbound/westbound priority demand into PRIORITY phases, with a no-back-to-back-priority starvation guard.

---
 rtl/ddi_phase_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_ddi_phase_scheduler.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ddi_phase_scheduler.sv
// ddi_phase_scheduler
// Times the residency of each diverging-diamond FSM state, alternates the two
// normal phases and arbitrates east/west priority demand into PRIORITY phases.
// Two PRIORITY phases are never granted back to back.

module ddi_phase_scheduler #(
    parameter int ALL_RED_CYC    = 2,
    parameter int GREEN_CYC      = 30,
    parameter int YELLOW_CYC     = 4,
    parameter int PRIO_GREEN_CYC = 15,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] state_in,
    input  logic       east_req,
    input  logic       west_req,
    input  logic       maint_req,
    output logic       timing_done,
    output logic [1:0] phase,
    output logic       sync,
    output logic       maintenance,
    output logic       east_served,
    output logic       west_served
);

    // FSM state codes
    localparam logic [3:0] ST_ALL_RED     = 4'd0;
    localparam logic [3:0] ST_P1_GREEN    = 4'd1;
    localparam logic [3:0] ST_P1_YELLOW   = 4'd2;
    localparam logic [3:0] ST_P2_GREEN    = 4'd3;
    localparam logic [3:0] ST_P2_YELLOW   = 4'd4;
    localparam logic [3:0] ST_EB_GREEN    = 4'd5;
    localparam logic [3:0] ST_EB_YELLOW   = 4'd6;
    localparam logic [3:0] ST_WB_GREEN    = 4'd7;
    localparam logic [3:0] ST_WB_YELLOW   = 4'd8;
    localparam logic [3:0] ST_MAINTENANCE = 4'd9;

    // phase / sync codes
    localparam logic [1:0] PH_1        = 2'd0;
    localparam logic [1:0] PH_2        = 2'd1;
    localparam logic [1:0] PH_PRIORITY = 2'd2;
    localparam logic       SY_EAST     = 1'b0;
    localparam logic       SY_WEST     = 1'b1;

    // Last residency index of each timed state (duration minus one)
    localparam logic [CNT_W-1:0] AR_LAST    = CNT_W'(ALL_RED_CYC - 1);
    localparam logic [CNT_W-1:0] GREEN_LAST = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] YEL_LAST   = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] PRIO_LAST  = CNT_W'(PRIO_GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    logic [3:0]       prev_state_q;
    logic             first_q;
    logic [CNT_W-1:0] res_q, res_d;
    logic [CNT_W-1:0] r_s;
    logic [CNT_W-1:0] dur_last_s;
    logic             dur_vld_s;
    logic             entry_s;
    logic             decide_s;

    logic             east_pend_q, east_pend_d;
    logic             west_pend_q, west_pend_d;
    logic             last_norm_q, last_norm_d;   // 0: PHASE_1, 1: PHASE_2
    logic             last_prio_q, last_prio_d;
    logic             rr_q, rr_d;                 // 0: east next, 1: west next
    logic [1:0]       phase_q, phase_d;
    logic             sync_q, sync_d;
    logic             maint_q;
    logic             east_served_q, west_served_q;

    // first_q makes the first cycle out of reset an entry cycle
    assign entry_s  = first_q | (state_in != prev_state_q);
    assign r_s      = entry_s ? {CNT_W{1'b0}} : res_q;
    assign decide_s = entry_s & (state_in == ST_ALL_RED);

    // Residency duration lookup for the observed state
    always_comb begin
        dur_vld_s  = 1'b1;
        dur_last_s = {CNT_W{1'b0}};
        case (state_in)
            ST_ALL_RED:                 dur_last_s = AR_LAST;
            ST_P1_GREEN, ST_P2_GREEN:   dur_last_s = GREEN_LAST;
            ST_P1_YELLOW, ST_P2_YELLOW,
            ST_EB_YELLOW, ST_WB_YELLOW: dur_last_s = YEL_LAST;
            ST_EB_GREEN, ST_WB_GREEN:   dur_last_s = PRIO_LAST;
            ST_MAINTENANCE:             dur_vld_s  = 1'b0;
            default:                    dur_vld_s  = 1'b0;
        endcase
    end

    assign timing_done = dur_vld_s & ~maint_q & (r_s == dur_last_s);

    // Next residency index: held at zero during maintenance, saturating otherwise
    always_comb begin
        res_d = r_s;
        if (maint_q) begin
            res_d = {CNT_W{1'b0}};
        end else if (r_s != CNT_MAX) begin
            res_d = r_s + CNT_ONE;
        end else begin
            res_d = r_s;
        end
    end

    // Pending demand: clearing on green entry overrides a same-cycle request
    always_comb begin
        east_pend_d = east_pend_q;
        west_pend_d = west_pend_q;
        if (entry_s && (state_in == ST_EB_GREEN)) begin
            east_pend_d = 1'b0;
        end else if (east_req && (state_in != ST_EB_GREEN) && (state_in != ST_EB_YELLOW)) begin
            east_pend_d = 1'b1;
        end else begin
            east_pend_d = east_pend_q;
        end
        if (entry_s && (state_in == ST_WB_GREEN)) begin
            west_pend_d = 1'b0;
        end else if (west_req && (state_in != ST_WB_GREEN) && (state_in != ST_WB_YELLOW)) begin
            west_pend_d = 1'b1;
        end else begin
            west_pend_d = west_pend_q;
        end
    end

    // Phase decision taken on the ALL_RED entry cycle
    always_comb begin
        phase_d     = phase_q;
        sync_d      = sync_q;
        last_norm_d = last_norm_q;
        last_prio_d = last_prio_q;
        rr_d        = rr_q;
        if (decide_s) begin
            if ((east_pend_q || west_pend_q) && !last_prio_q) begin
                phase_d     = PH_PRIORITY;
                last_prio_d = 1'b1;
                if (east_pend_q && west_pend_q) begin
                    sync_d = rr_q ? SY_WEST : SY_EAST;
                    rr_d   = ~rr_q;
                end else if (east_pend_q) begin
                    sync_d = SY_EAST;
                end else begin
                    sync_d = SY_WEST;
                end
            end else begin
                phase_d     = last_norm_q ? PH_1 : PH_2;
                last_norm_d = ~last_norm_q;
                last_prio_d = 1'b0;
            end
        end else begin
            phase_d = phase_q;
        end
    end

    // State register for residency, arbitration and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_state_q  <= ST_ALL_RED;
            first_q       <= 1'b1;
            res_q         <= {CNT_W{1'b0}};
            east_pend_q   <= 1'b0;
            west_pend_q   <= 1'b0;
            last_norm_q   <= 1'b1;
            last_prio_q   <= 1'b0;
            rr_q          <= 1'b0;
            phase_q       <= PH_1;
            sync_q        <= SY_EAST;
            maint_q       <= 1'b0;
            east_served_q <= 1'b0;
            west_served_q <= 1'b0;
        end else begin
            prev_state_q  <= state_in;
            first_q       <= 1'b0;
            res_q         <= res_d;
            east_pend_q   <= east_pend_d;
            west_pend_q   <= west_pend_d;
            last_norm_q   <= last_norm_d;
            last_prio_q   <= last_prio_d;
            rr_q          <= rr_d;
            phase_q       <= phase_d;
            sync_q        <= sync_d;
            maint_q       <= maint_req;
            east_served_q <= entry_s & (state_in == ST_EB_GREEN);
            west_served_q <= entry_s & (state_in == ST_WB_GREEN);
        end
    end

    assign phase       = phase_q;
    assign sync        = sync_q;
    assign maintenance = maint_q;
    assign east_served = east_served_q;
    assign west_served = west_served_q;

endmodule

// File: tb/tb_ddi_phase_scheduler.sv
// Bench for ddi_phase_scheduler: a small behavioural signal FSM closes the
// loop; expected state runs (state, length, strobes, phase/sync) are queued
// by the stimulus and a negedge monitor compares each completed run.

module tb_ddi_phase_scheduler;

    localparam logic [3:0] AR  = 4'd0, P1G = 4'd1, P1Y = 4'd2, P2G = 4'd3, P2Y = 4'd4;
    localparam logic [3:0] EBG = 4'd5, EBY = 4'd6, WBG = 4'd7, WBY = 4'd8, MT  = 4'd9;
    localparam logic [1:0] PH1 = 2'd0, PH2 = 2'd1, PRIO = 2'd2;
    localparam logic       E = 1'b0, W = 1'b1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] fsm_st;
    logic       east_req = 1'b0, west_req = 1'b0, maint_req = 1'b0;
    logic       timing_done, sync, maintenance, east_served, west_served;
    logic [1:0] phase;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] st;
        int         len, td, es, ws, mc;
        logic [1:0] ph;
        bit         ck_ph;
        logic       sy;
        bit         ck_sy;
    } item_t;
    item_t sb[$];

    ddi_phase_scheduler #(
        .ALL_RED_CYC(2), .GREEN_CYC(8), .YELLOW_CYC(3), .PRIO_GREEN_CYC(5), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .state_in(fsm_st),
        .east_req(east_req), .west_req(west_req), .maint_req(maint_req),
        .timing_done(timing_done), .phase(phase), .sync(sync),
        .maintenance(maintenance), .east_served(east_served), .west_served(west_served)
    );

    always #5 clk = ~clk;

    // Behavioural diverging-diamond signal FSM driven by the scheduler
    always @(posedge clk or posedge rst) begin
        if (rst) fsm_st <= AR;
        else if (maintenance && fsm_st != MT) fsm_st <= MT;
        else begin
            case (fsm_st)
                MT:  if (!maintenance) fsm_st <= AR;
                AR:  if (timing_done) fsm_st <= (phase == PH1) ? P1G : (phase == PH2) ? P2G :
                                                (sync == W) ? WBG : EBG;
                P1G: if (timing_done) fsm_st <= P1Y;
                P2G: if (timing_done) fsm_st <= P2Y;
                EBG: if (timing_done) fsm_st <= EBY;
                WBG: if (timing_done) fsm_st <= WBY;
                P1Y, P2Y, EBY, WBY: if (timing_done) fsm_st <= AR;
                default: fsm_st <= AR;
            endcase
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] st, input int len, input int td, input int es,
                        input int ws, input int mc, input logic [1:0] ph, input bit ck_ph,
                        input logic sy, input bit ck_sy);
        item_t it;
        it.st = st; it.len = len; it.td = td; it.es = es; it.ws = ws; it.mc = mc;
        it.ph = ph; it.ck_ph = ck_ph; it.sy = sy; it.ck_sy = ck_sy;
        sb.push_back(it);
    endtask

    task automatic ps(input logic [3:0] st, input int len);
        push(st, len, 1, 0, 0, 0, PH1, 1'b0, E, 1'b0);
    endtask
    task automatic pr(input logic [1:0] ph);
        push(AR, 2, 1, 0, 0, 0, ph, 1'b1, E, 1'b0);
    endtask
    task automatic pp(input logic sy);
        push(AR, 2, 1, 0, 0, 0, PRIO, 1'b1, sy, 1'b1);
    endtask
    task automatic eb();
        push(EBG, 5, 1, 1, 0, 0, PH1, 1'b0, E, 1'b0); ps(EBY, 3);
    endtask
    task automatic wb();
        push(WBG, 5, 1, 0, 1, 0, PH1, 1'b0, E, 1'b0); ps(WBY, 3);
    endtask

    task automatic wait_state(input logic [3:0] s);
        int n = 0;
        while (fsm_st != s && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("wait_state", int'(fsm_st), int'(s));
    endtask

    task automatic check_reset_outputs();
        check("rst_timing_done", int'(timing_done), 0);
        check("rst_phase", int'(phase), int'(PH1));
        check("rst_sync", int'(sync), int'(E));
        check("rst_maintenance", int'(maintenance), 0);
        check("rst_east_served", int'(east_served), 0);
        check("rst_west_served", int'(west_served), 0);
    endtask

    // Run monitor: accumulate one FSM state run, compare it when the state changes
    logic [3:0] cur_st;
    int         r_len, r_td, r_es, r_ws, r_mc;
    logic [1:0] r_ph;
    logic       r_sy;
    bit         started = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            started = 1'b0;
        end else begin
            if (started && fsm_st == cur_st) begin
                r_len++;
            end else begin
                if (started) begin
                    if (sb.size() == 0) begin
                        check("unexpected_run_state", int'(cur_st), 15);
                    end else begin
                        item_t it;
                        it = sb.pop_front();
                        check("run_state", int'(cur_st), int'(it.st));
                        check("run_length", r_len, it.len);
                        check("timing_done_count", r_td, it.td);
                        check("east_served_count", r_es, it.es);
                        check("west_served_count", r_ws, it.ws);
                        check("maintenance_cycles", r_mc, it.mc);
                        if (it.ck_ph) check("phase_decision", int'(r_ph), int'(it.ph));
                        if (it.ck_sy) check("sync_decision", int'(r_sy), int'(it.sy));
                    end
                end
                started = 1'b1;
                cur_st  = fsm_st;
                r_len   = 1;
                r_td = 0; r_es = 0; r_ws = 0; r_mc = 0;
            end
            r_td += int'(timing_done);
            r_es += int'(east_served);
            r_ws += int'(west_served);
            r_mc += int'(maintenance);
            r_ph  = phase;
            r_sy  = sync;
        end
    end

    // Directed stimulus
    initial begin
        @(posedge clk); #1;
        check_reset_outputs();
        // 1: free-running normal phases
        pr(PH1); ps(P1G, 8); ps(P1Y, 3); pr(PH2); ps(P2G, 8); ps(P2Y, 3); pr(PH1);
        @(posedge clk); #1 rst = 1'b0;
        wait_state(P1G); wait_state(P2G); wait_state(P1G);
        // 2: single-cycle east pulse during P1G
        ps(P1G, 8); ps(P1Y, 3); pp(E); eb(); pr(PH2);
        east_req = 1'b1;
        @(negedge clk);
        east_req = 1'b0;
        wait_state(P2G);
        // 3/6: both directions held: priority alternates with normal phases
        ps(P2G, 8); ps(P2Y, 3); pp(E); eb(); pr(PH1); ps(P1G, 8); ps(P1Y, 3);
        pp(W); wb(); pr(PH2); ps(P2G, 8); ps(P2Y, 3); pp(E); eb(); pr(PH1);
        ps(P1G, 8); ps(P1Y, 3); pp(W); wb(); pr(PH2);
        east_req = 1'b1; west_req = 1'b1;
        wait_state(EBG); wait_state(WBG); wait_state(EBG);
        east_req = 1'b0; west_req = 1'b0;
        wait_state(WBG); wait_state(P2G);
        // 4: maintenance for 10 cycles from r=3 of P2G
        push(P2G, 5, 0, 0, 0, 1, PH1, 1'b0, E, 1'b0);
        push(MT, 10, 0, 0, 0, 9, PH1, 1'b0, E, 1'b0);
        pr(PH1);
        repeat (3) @(negedge clk);
        maint_req = 1'b1;
        repeat (10) @(negedge clk);
        maint_req = 1'b0;
        // 5: asynchronous reset at r=4 of P1G
        wait_state(P1G);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs();
        pr(PH1); ps(P1G, 8); ps(P1Y, 3); pr(PH2);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    // Watchdog against a stalled run
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d expected runs outstanding", sb.size());
        $fatal(1, "watchdog expired");
    end

endmodule
